// File: rtl/pointer_seq.sv
// Command sequencer for the pointer_pair IP/DP register pair: byte-level commands in, active-low strobes out.
// Optional feature: define POINTER_SEQ_JMP_EN to enable JMP (load DP, then swap so the old IP becomes the return address).
module pointer_seq #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       addr_dp_req,
  output logic       rd_valid,
  output logic       busy,
  output logic       err,
  output logic [7:0] di,
  output logic       we_l,
  output logic       we_h,
  output logic       oe_addr_ip,
  output logic       oe_addr_dp,
  output logic       oe_dl,
  output logic       oe_dh,
  output logic       cnt,
  output logic       selector
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LD_LO = 4'd1;
  localparam logic [3:0] S_WR_LO = 4'd2;
  localparam logic [3:0] S_LD_HI = 4'd3;
  localparam logic [3:0] S_WR_HI = 4'd4;
  localparam logic [3:0] S_SWAP  = 4'd5;
  localparam logic [3:0] S_INC   = 4'd6;
  localparam logic [3:0] S_RD_LO = 4'd7;
  localparam logic [3:0] S_RD_HI = 4'd8;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_LDP = 3'd1;
  localparam logic [2:0] CMD_SWP = 3'd2;
  localparam logic [2:0] CMD_JMP = 3'd3;
  localparam logic [2:0] CMD_RDP = 3'd4;
  localparam logic [2:0] CMD_INC = 3'd5;

  localparam bit            TO_EN    = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  logic [3:0]      state_r, state_s;
  logic            jmp_r, jmp_s;
  logic [TO_W-1:0] to_cnt_r, to_cnt_s;
  logic [7:0]      di_s;
  logic            err_s;
  logic            addr_dp_s;

  assign addr_dp_s = (state_r == S_IDLE) && addr_dp_req;

  // Next-state, operand capture and operand-timeout decisions.
  always_comb begin
    state_s  = state_r;
    jmp_s    = jmp_r;
    to_cnt_s = to_cnt_r;
    di_s     = di;
    err_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_NOP: state_s = S_IDLE;
            CMD_LDP: begin
              state_s  = S_LD_LO;
              jmp_s    = 1'b0;
              to_cnt_s = {TO_W{1'b0}};
            end
`ifdef POINTER_SEQ_JMP_EN
            CMD_JMP: begin
              state_s  = S_LD_LO;
              jmp_s    = 1'b1;
              to_cnt_s = {TO_W{1'b0}};
            end
`endif
            CMD_SWP: state_s = S_SWAP;
            CMD_RDP: state_s = S_RD_LO;
            CMD_INC: state_s = S_INC;
            default: err_s = 1'b1;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LD_LO, S_LD_HI: begin
        if (byte_valid) begin
          di_s    = byte_in;
          state_s = (state_r == S_LD_LO) ? S_WR_LO : S_WR_HI;
        end else begin
          // The abort fires on the idle cycle that brings the count up to TIMEOUT.
          to_cnt_s = TO_EN ? (to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1}) : to_cnt_r;
          if (TO_EN && (to_cnt_s == TO_LIMIT)) begin
            state_s = S_IDLE;
            err_s   = 1'b1;
          end else begin
            state_s = state_r;
          end
        end
      end
      S_WR_LO: begin
        state_s  = S_LD_HI;
        to_cnt_s = {TO_W{1'b0}};
      end
      S_WR_HI: state_s = jmp_r ? S_SWAP : S_IDLE;
      S_RD_LO: state_s = S_RD_HI;
      S_SWAP, S_INC, S_RD_HI: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State and registered strobes; strobes are decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      jmp_r      <= 1'b0;
      to_cnt_r   <= {TO_W{1'b0}};
      di         <= 8'h00;
      err        <= 1'b0;
      we_l       <= 1'b1;
      we_h       <= 1'b1;
      oe_dl      <= 1'b1;
      oe_dh      <= 1'b1;
      rd_valid   <= 1'b0;
      cnt        <= 1'b0;
      selector   <= 1'b0;
      oe_addr_ip <= 1'b0;
      oe_addr_dp <= 1'b1;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      byte_ready <= 1'b0;
    end else begin
      state_r    <= state_s;
      jmp_r      <= jmp_s;
      to_cnt_r   <= to_cnt_s;
      di         <= di_s;
      err        <= err_s;
      we_l       <= (state_s != S_WR_LO);
      we_h       <= (state_s != S_WR_HI);
      oe_dl      <= (state_s != S_RD_LO);
      oe_dh      <= (state_s != S_RD_HI);
      rd_valid   <= (state_s == S_RD_LO) || (state_s == S_RD_HI);
      cnt        <= (state_s == S_INC);
      selector   <= (state_r == S_SWAP) ? ~selector : selector;
      oe_addr_ip <= addr_dp_s;
      oe_addr_dp <= ~addr_dp_s;
      cmd_ready  <= (state_s == S_IDLE);
      busy       <= (state_s != S_IDLE);
      byte_ready <= (state_s == S_LD_LO) || (state_s == S_LD_HI);
    end
  end

endmodule
